// File: rtl/pattern_tx4.sv
// rtl/pattern_tx4.sv - serializes a recirculating match pattern and signal words in lockstep frames
// Feeds the serial pattern detector: prgm repeats the stored pattern every frame, sig carries words or FILL.
module pattern_tx4 #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] prgm_data,
  input  logic             prgm_valid,
  output logic             prgm_ready,
  input  logic [WIDTH-1:0] sig_data,
  input  logic             sig_valid,
  output logic             sig_ready,
  input  logic             stop,
  output logic             prgm,
  output logic             sig,
  output logic             frame_last,
  output logic             cmp_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] prgm_sh_q, prgm_sh_d;
  logic [WIDTH-1:0] sig_sh_q, sig_sh_d;
  logic             word_pending_q, word_pending_d;
  logic             cmp_valid_q;

  logic run, at_last, boundary, prgm_xfer, sig_xfer;

  assign run        = (state_q == RUN);
  assign at_last    = run && (bit_cnt_q == LAST);
  assign boundary   = !run || at_last;
  assign prgm_ready = boundary;
  assign sig_ready  = at_last && !stop;
  assign prgm_xfer  = prgm_valid && boundary;
  assign sig_xfer   = sig_valid && sig_ready;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    pat_d          = pat_q;
    prgm_sh_d      = prgm_sh_q;
    sig_sh_d       = sig_sh_q;
    word_pending_d = word_pending_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (prgm_xfer) begin
          state_d        = RUN;
          pat_d          = prgm_data;
          prgm_sh_d      = prgm_data;
          sig_sh_d       = '0;
          word_pending_d = 1'b0;
        end
      end
      RUN: begin
        if (at_last) begin
          // Frame boundary: reload both shifters; a new pattern only affects the next frame.
          bit_cnt_d      = '0;
          pat_d          = prgm_xfer ? prgm_data : pat_q;
          prgm_sh_d      = prgm_xfer ? prgm_data : pat_q;
          sig_sh_d       = sig_xfer ? sig_data : '0;
          word_pending_d = sig_xfer;
          if (stop) begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          prgm_sh_d = {prgm_sh_q[WIDTH-2:0], 1'b0};
          sig_sh_d  = {sig_sh_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      pat_q          <= '0;
      prgm_sh_q      <= '0;
      sig_sh_q       <= '0;
      word_pending_q <= 1'b0;
      cmp_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      pat_q          <= pat_d;
      prgm_sh_q      <= prgm_sh_d;
      sig_sh_q       <= sig_sh_d;
      word_pending_q <= word_pending_d;
      cmp_valid_q    <= at_last;
    end
  end

  assign prgm       = run && prgm_sh_q[WIDTH-1];
  assign sig        = run && (word_pending_q ? sig_sh_q[WIDTH-1] : FILL);
  assign frame_last = at_last;
  assign cmp_valid  = cmp_valid_q;
  assign busy       = run;

endmodule

// File: tb/tb_pattern_tx4.sv
// tb/tb_pattern_tx4.sv - scoreboard bench for pattern_tx4 (WIDTH=4) plus a WIDTH=5/FILL=1 instance
module tb_pattern_tx4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] prgm_data = '0, sig_data = '0;
  logic       prgm_valid = 1'b0, sig_valid = 1'b0, stop = 1'b0;
  logic       prgm_ready, sig_ready, prgm, sig, frame_last, cmp_valid, busy;

  logic [4:0] prgm_data5 = '0, sig_data5 = '0;
  logic       prgm_valid5 = 1'b0;
  logic       prgm_ready5, sig_ready5, prgm5, sig5, frame_last5, cmp_valid5, busy5;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  logic       cmp_q[$];

  logic       m_run = 1'b0;
  int         m_cnt = 0;
  logic [3:0] m_pat = '0;
  logic       m_cmp = 1'b0;

  logic [3:0] det_p = '0, det_s = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    det_p <= {det_p[2:0], prgm};
    det_s <= {det_s[2:0], sig};
  end

  pattern_tx4 #(.WIDTH(4), .FILL(1'b0)) dut (
    .clk(clk), .clr(clr),
    .prgm_data(prgm_data), .prgm_valid(prgm_valid), .prgm_ready(prgm_ready),
    .sig_data(sig_data), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .stop(stop), .prgm(prgm), .sig(sig), .frame_last(frame_last),
    .cmp_valid(cmp_valid), .busy(busy)
  );

  pattern_tx4 #(.WIDTH(5), .FILL(1'b1)) dut5 (
    .clk(clk), .clr(clr),
    .prgm_data(prgm_data5), .prgm_valid(prgm_valid5), .prgm_ready(prgm_ready5),
    .sig_data(sig_data5), .sig_valid(1'b0), .sig_ready(sig_ready5),
    .stop(1'b0), .prgm(prgm5), .sig(sig5), .frame_last(frame_last5),
    .cmp_valid(cmp_valid5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check readies against the model, then check serial outputs.
  task automatic step(input logic pv, input logic [3:0] pd, input logic sv, input logic [3:0] sd,
                      input logic st);
    logic       bnd, pxfer, sxfer, nxt_run, got_cmp;
    logic [3:0] word;
    logic [2:0] e;
    prgm_valid = pv; prgm_data = pd; sig_valid = sv; sig_data = sd; stop = st;
    #1;
    bnd = !m_run || (m_cnt == 3);
    check("prgm_ready", prgm_ready, bnd);
    check("sig_ready", sig_ready, m_run && m_cnt == 3 && !st);
    pxfer = pv && bnd;
    sxfer = sv && m_run && m_cnt == 3 && !st;
    if (pxfer) m_pat = pd;
    nxt_run = m_run;
    if (bnd) begin
      nxt_run = m_run ? !st : pxfer;
      if (nxt_run) begin
        word = sxfer ? sd : 4'b0000;
        for (int k = 0; k < 4; k++) exp_q.push_back({m_pat[3-k], word[3-k], k == 3});
        cmp_q.push_back(word == m_pat);
      end
    end
    @(posedge clk); #1;
    m_cmp = m_run && (m_cnt == 3);
    m_cnt = (m_run && m_cnt != 3) ? m_cnt + 1 : 0;
    m_run = nxt_run;
    check("busy", busy, m_run);
    if (m_run) begin
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("prgm", prgm, e[2]);
        check("sig", sig, e[1]);
        check("frame_last", frame_last, e[0]);
      end
    end else begin
      check("idle_prgm", prgm, 0);
      check("idle_sig", sig, 0);
      check("idle_frame_last", frame_last, 0);
    end
    check("cmp_valid", cmp_valid, m_cmp);
    if (m_cmp) begin
      if (cmp_q.size() == 0) check("cmp_q_empty", 1, 0);
      else begin
        got_cmp = (det_p == det_s);
        check("detector_out", got_cmp, cmp_q.pop_front());
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 4'h0, 0);
  endtask

  task automatic go_to_boundary();
    int guard = 0;
    while (!(m_run && m_cnt == 3) && guard < 8) begin
      step(0, 4'h0, 0, 4'h0, 0);
      guard++;
    end
    if (!(m_run && m_cnt == 3)) check("boundary_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_prgm_ready", prgm_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_prgm", prgm, 0);
    check("rst_sig", sig, 0);
    check("rst_cmp_valid", cmp_valid, 0);
    check("rst_sig_ready", sig_ready, 0);
    clr = 1'b1;

    // Program 1011, no words: fill frames
    step(1, 4'b1011, 0, 4'h0, 0);
    idle_steps(9);

    // Two back-to-back words: match then mismatch
    go_to_boundary();
    step(0, 4'h0, 1, 4'b1011, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1, 4'b0110, 0);
    step(0, 4'h0, 1, 4'b0110, 0);
    idle_steps(6);

    // Pattern change offered mid-frame
    go_to_boundary();
    step(1, 4'b1100, 0, 4'h0, 0);
    for (int i = 0; i < 4; i++) step(1, 4'b0001, 0, 4'h0, 0);
    idle_steps(9);

    // Stop together with sig_valid at the boundary
    go_to_boundary();
    step(0, 4'h0, 1, 4'b1111, 1);
    idle_steps(3);

    // Mid-frame reset with a word in flight
    step(1, 4'b1011, 0, 4'h0, 0);
    go_to_boundary();
    step(0, 4'h0, 1, 4'b0110, 0);
    idle_steps(2);
    check("pre_rst_cnt", m_cnt, 2);
    clr = 1'b0;
    #1;
    check("mid_rst_prgm", prgm, 0);
    check("mid_rst_sig", sig, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_last", frame_last, 0);
    check("mid_rst_prgm_ready", prgm_ready, 1);
    exp_q.delete();
    cmp_q.delete();
    m_run = 1'b0; m_cnt = 0; m_cmp = 1'b0; m_pat = '0;
    @(posedge clk); #1;
    clr = 1'b1;
    idle_steps(5);

    // WIDTH=5, FILL=1, pattern 10010
    prgm_valid5 = 1'b1; prgm_data5 = 5'b10010;
    #1;
    check("w5_prgm_ready", prgm_ready5, 1);
    @(posedge clk); #1;
    prgm_valid5 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      check("w5_busy", busy5, 1);
      check("w5_prgm", prgm5, prgm_data5[4 - (k % 5)]);
      check("w5_sig", sig5, 1);
      check("w5_frame_last", frame_last5, (k % 5) == 4);
      check("w5_prgm_ready", prgm_ready5, (k % 5) == 4);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
